// File: rtl/btn_press_ctrl.sv
// Button press controller: synchronise, debounce, classify short/long presses, sequence the LED counter.
// Optional long-press detection is built when BTN_PRESS_LONG_EN is defined.
module btn_press_ctrl #(
  parameter int DB_CYCLES   = 1_000_000,
  parameter int LONG_CYCLES = 100_000_000,
  parameter int LED_W       = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             btn,
  output logic [LED_W-1:0] led,
  output logic             short_pulse,
  output logic             long_pulse,
  output logic             busy
);

  localparam int DB_W = $clog2(DB_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  if (DB_CYCLES < 2 || LONG_CYCLES <= DB_CYCLES) begin : g_param_check
    $error("btn_press_ctrl: need DB_CYCLES >= 2 and LONG_CYCLES > DB_CYCLES");
  end

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } state_t;

  state_t          state;
  logic            btn_m;
  logic            btn_s;
  logic [1:0]      sync_vld;
  logic            armed;
  logic [DB_W-1:0] db_cnt;
  logic            long_done;

`ifdef BTN_PRESS_LONG_EN
  localparam int HOLD_W = $clog2(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(LONG_CYCLES - 2);

  logic [HOLD_W-1:0] hold_cnt;
  logic              long_flag;

  assign long_done = long_flag;
`else
  assign long_done  = 1'b0;
  assign long_pulse = 1'b0;
`endif

  // The synchroniser flops reset to 0, so btn_s only reflects the pin once
  // sync_vld has filled; arming waits for that so a button held through
  // reset is not mistaken for a release.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      btn_m       <= 1'b0;
      btn_s       <= 1'b0;
      sync_vld    <= 2'b00;
      armed       <= 1'b0;
      state       <= IDLE;
      db_cnt      <= '0;
      led         <= '0;
      short_pulse <= 1'b0;
      busy        <= 1'b0;
`ifdef BTN_PRESS_LONG_EN
      hold_cnt    <= '0;
      long_flag   <= 1'b0;
      long_pulse  <= 1'b0;
`endif
    end else begin
      btn_m       <= btn;
      btn_s       <= btn_m;
      sync_vld    <= {sync_vld[0], 1'b1};
      short_pulse <= 1'b0;
`ifdef BTN_PRESS_LONG_EN
      long_pulse  <= 1'b0;
`endif
      if (sync_vld[1] && !btn_s) armed <= 1'b1;

      case (state)
        IDLE: begin
          if (armed && btn_s) begin
            state  <= DB_PRESS;
            db_cnt <= '0;
            busy   <= 1'b1;
          end
        end
        DB_PRESS: begin
          if (!btn_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (db_cnt == DB_LAST) begin
            state <= HELD;
`ifdef BTN_PRESS_LONG_EN
            hold_cnt  <= '0;
            long_flag <= 1'b0;
`endif
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        HELD: begin
`ifdef BTN_PRESS_LONG_EN
          // Threshold is evaluated even on the cycle the button falls, so
          // the long action wins over a coincident release.
          if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 1'b1;
            if (hold_cnt == HOLD_PRE && !long_flag) begin
              long_flag  <= 1'b1;
              long_pulse <= 1'b1;
              led        <= '0;
            end
          end
`endif
          if (!btn_s) begin
            state  <= DB_RELEASE;
            db_cnt <= '0;
          end
        end
        DB_RELEASE: begin
          if (btn_s) begin
            state  <= HELD;
            db_cnt <= '0;
          end else if (db_cnt == DB_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (!long_done) begin
              short_pulse <= 1'b1;
              led         <= led + 1'b1;
            end
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_press_ctrl.sv
// Bench for btn_press_ctrl with DB_CYCLES=4, LONG_CYCLES=20, LED_W=4.
// Pulse events are queued as {long, short, led, cycle} and checked by a monitor.
module tb_btn_press_ctrl;

  localparam int DB_CYCLES   = 4;
  localparam int LONG_CYCLES = 20;
  localparam int LED_W       = 4;
  localparam int EW          = 2 + LED_W + 16;

  logic             clk;
  logic             reset_n;
  logic             btn;
  logic [LED_W-1:0] led;
  logic             short_pulse;
  logic             long_pulse;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [EW-1:0] exp_q[$];

  btn_press_ctrl #(
    .DB_CYCLES  (DB_CYCLES),
    .LONG_CYCLES(LONG_CYCLES),
    .LED_W      (LED_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .btn        (btn),
    .led        (led),
    .short_pulse(short_pulse),
    .long_pulse (long_pulse),
    .busy       (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- driver / checker tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic is_long, input logic is_short,
                          input logic [LED_W-1:0] led_v, input int at_cyc);
    logic [15:0] c;
    c = at_cyc[15:0];
    exp_q.push_back({is_long, is_short, led_v, c});
  endtask

  task automatic check_drained(input string name);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    btn     = 1'b0;
    reset_n = 1'b0;
    wait_cycles(2);
    check("reset_led", led, 0);
    check("reset_busy", busy, 0);
    check("reset_pulses", {long_pulse, short_pulse}, 0);
    reset_n = 1'b1;
    wait_cycles(4);
  endtask

  // Press 10 cycles, release 10: short pulse 17 cycles after the press is driven.
  task automatic short_press(input logic [LED_W-1:0] led_after);
    int t0;
    t0 = cyc;
    push_exp(1'b0, 1'b1, led_after, t0 + 17);
    btn = 1'b1;
    wait_cycles(10);
    btn = 1'b0;
    wait_cycles(10);
  endtask

  // ---------------- monitor ----------------
  task automatic monitor_loop();
    logic [EW-1:0] e;
    logic [EW-1:0] got;
    forever begin
      @(negedge clk);
      if (reset_n && (short_pulse || long_pulse)) begin
        got = {long_pulse, short_pulse, led, cyc[15:0]};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: got long=%0b short=%0b led=%0d cycle %0d, expected none",
                   long_pulse, short_pulse, led, cyc);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL pulse_event: got long=%0b short=%0b led=%0d cycle %0d, expected long=%0b short=%0b led=%0d cycle %0d",
                     got[EW-1], got[EW-2], got[15+LED_W:16], got[15:0],
                     e[EW-1], e[EW-2], e[15+LED_W:16], e[15:0]);
          end
        end
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    btn     = 1'b0;
    reset_n = 1'b0;
    fork
      monitor_loop();
    join_none

    // 1: 3-cycle bounce is rejected
    do_reset();
    btn = 1'b1;
    wait_cycles(3);
    btn = 1'b0;
    wait_cycles(1);
    check("bounce_busy_high", busy, 1);
    wait_cycles(6);
    check("bounce_busy_low", busy, 0);
    check("bounce_led", led, 0);
    check_drained("bounce_no_pulse");

    // 2: single short press
    do_reset();
    t0 = cyc;
    push_exp(1'b0, 1'b1, 4'd1, t0 + 17);
    btn = 1'b1;
    wait_cycles(8);
    check("short_busy_held", busy, 1);
    wait_cycles(2);
    btn = 1'b0;
    wait_cycles(10);
    check("short_led", led, 1);
    check("short_busy_idle", busy, 0);
    check_drained("short_all_pulses");

    // 3: release glitch returns to HELD, single short pulse later
    do_reset();
    t0 = cyc;
    push_exp(1'b0, 1'b1, 4'd1, t0 + 20);
    btn = 1'b1;
    wait_cycles(10);
    btn = 1'b0;
    wait_cycles(2);
    btn = 1'b1;
    wait_cycles(1);
    btn = 1'b0;
    wait_cycles(15);
    check("glitch_led", led, 1);
    check_drained("glitch_single_pulse");

    // 4: long press after one short press
    do_reset();
    short_press(4'd1);
    t0 = cyc;
`ifdef BTN_PRESS_LONG_EN
    push_exp(1'b1, 1'b0, 4'd0, t0 + 26);
`else
    push_exp(1'b0, 1'b1, 4'd2, t0 + 47);
`endif
    btn = 1'b1;
    wait_cycles(40);
    btn = 1'b0;
    wait_cycles(12);
`ifdef BTN_PRESS_LONG_EN
    check("long_led", led, 0);
`else
    check("long_led", led, 2);
`endif
    check("long_busy_idle", busy, 0);
    check_drained("long_pulses");

    // 5: 17 short presses wrap the counter
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      logic [LED_W-1:0] v;
      v = LED_W'(i % 16);
      short_press(v);
    end
    check("wrap_led", led, 1);
    check_drained("wrap_pulses");

    // 6: reset mid-press with the button held through it
    do_reset();
    btn = 1'b1;
    wait_cycles(10);
    reset_n = 1'b0;
    wait_cycles(2);
    check("midreset_led", led, 0);
    check("midreset_busy", busy, 0);
    reset_n = 1'b1;
    wait_cycles(15);
    check("held_through_reset_busy", busy, 0);
    wait_cycles(15);
    btn = 1'b0;
    wait_cycles(10);
    check("held_through_reset_led", led, 0);
    check_drained("held_through_reset_no_pulse");
    short_press(4'd1);
    check("after_rearm_led", led, 1);
    check_drained("after_rearm_pulse");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
